parallel_adder: RTL and testbench



---
 rtl/parallel_adder_if.sv | 37 +++
 rtl/parallel_adder.sv | 106 ++++++++++
 tb/tb_parallel_adder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/parallel_adder_if.sv
// Operand/result bundle for parallel_adder; the flag signals exist only when
// ADDER_FLAGS_EN is defined.
interface parallel_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDER_FLAGS_EN
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin,
    input  out_valid, sum, cout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, cin,
    output out_valid, sum, cout, zero, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin,
    input  out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin,
    output out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/parallel_adder.sv
// WIDTH-bit ripple-carry adder with registered sum/cout (1-cycle latency).
// Optional zero/ovf flags are built only when ADDER_FLAGS_EN is defined.
module parallel_adder #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  parallel_adder_if.slave bus
);

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (c & (x ^ y));
  endfunction

  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             in_valid_i;

  assign a_i        = bus.a;
  assign b_i        = bus.b;
  assign cin_i      = bus.cin;
  assign in_valid_i = bus.in_valid;

  // Ripple chain: carry_c[i] enters cell i, carry_c[WIDTH] is the carry-out.
  logic [WIDTH:0]   carry_c;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;

  assign carry_c[0] = cin_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum_c[i]       = fa_sum(a_i[i], b_i[i], carry_c[i]);
    assign carry_c[i + 1] = fa_carry(a_i[i], b_i[i], carry_c[i]);
  end

  assign cout_c = carry_c[WIDTH];

  logic [WIDTH-1:0] sum_d,       sum_q;
  logic             cout_d,      cout_q;
  logic             out_valid_d, out_valid_q;

  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = 1'b0;
    if (in_valid_i) begin
      sum_d       = sum_c;
      cout_d      = cout_c;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = out_valid_q;

`ifdef ADDER_FLAGS_EN
  // Signed overflow: like-signed operands producing a result of the other sign.
  logic zero_c, ovf_c;
  logic zero_d, zero_q;
  logic ovf_d,  ovf_q;

  assign zero_c = (sum_c == '0);
  assign ovf_c  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_c[WIDTH-1] != a_i[WIDTH-1]);

  always_comb begin
    zero_d = zero_q;
    ovf_d  = ovf_q;
    if (in_valid_i) begin
      zero_d = zero_c;
      ovf_d  = ovf_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_parallel_adder.sv
// Directed bench for parallel_adder (WIDTH=8): vector table plus reset/hold sequences.
module tb_parallel_adder;

  localparam int WIDTH = 8;
  localparam int NVEC  = 9;

  logic clk;
  logic rst;

  parallel_adder_if #(.WIDTH(WIDTH)) bus ();

  parallel_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       zero;
    logic       ovf;
  } vec_t;

  vec_t vecs [NVEC];

  int checks;
  int errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
  endtask

  initial begin
    logic [7:0] held_sum;
    logic       held_cout;

    checks = 0;
    errors = 0;

    //          a      b      cin   sum    cout  zero  ovf
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h0F, 8'h0F, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    drive(1'b1, 8'h12, 8'h34, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("reset_sum", 64'(bus.sum), 64'h0);
    check("reset_cout", 64'(bus.cout), 64'h0);
    check("reset_valid", 64'(bus.out_valid), 64'h0);

    // Release reset with no valid input: outputs must stay cleared.
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 8'h12, 8'h34, 1'b1);
    @(posedge clk);
    #1;
    check("post_reset_sum", 64'(bus.sum), 64'h0);
    check("post_reset_valid", 64'(bus.out_valid), 64'h0);

    // Back-to-back vectors, one per cycle.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_sum", i), 64'(bus.sum), 64'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 64'(bus.cout), 64'(vecs[i].cout));
      check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'h1);
`ifdef ADDER_FLAGS_EN
      check($sformatf("vec%0d_zero", i), 64'(bus.zero), 64'(vecs[i].zero));
      check($sformatf("vec%0d_ovf", i), 64'(bus.ovf), 64'(vecs[i].ovf));
`endif
    end

    // Hold: load a known result, then change operands with in_valid low.
    @(negedge clk);
    drive(1'b1, 8'h21, 8'h43, 1'b0);
    held_sum  = 8'h64;
    held_cout = 1'b0;
    @(posedge clk);
    #1;
    check("hold_load_sum", 64'(bus.sum), 64'(held_sum));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b0, 8'hF0 + 8'(k), 8'hF0, 1'b1);
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_sum", k), 64'(bus.sum), 64'(held_sum));
      check($sformatf("hold%0d_cout", k), 64'(bus.cout), 64'(held_cout));
      check($sformatf("hold%0d_valid", k), 64'(bus.out_valid), 64'h0);
    end

    // Asynchronous reset between edges while a result is valid.
    @(negedge clk);
    drive(1'b1, 8'hFF, 8'hFF, 1'b1);
    @(posedge clk);
    #1;
    check("pre_async_valid", 64'(bus.out_valid), 64'h1);
    check("pre_async_cout", 64'(bus.cout), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_sum", 64'(bus.sum), 64'h0);
    check("async_cout", 64'(bus.cout), 64'h0);
    check("async_valid", 64'(bus.out_valid), 64'h0);
    @(posedge clk);
    #1;
    check("async_held_sum", 64'(bus.sum), 64'h0);
    check("async_held_valid", 64'(bus.out_valid), 64'h0);

    // Recovery after reset: first valid capture updates outputs.
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'h7F, 8'h01, 1'b0);
    @(posedge clk);
    #1;
    check("recover_sum", 64'(bus.sum), 64'h80);
    check("recover_valid", 64'(bus.out_valid), 64'h1);

    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check("final_valid", 64'(bus.out_valid), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
